// File: rtl/axis_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : axis_ctrl_pkg
//  Description : Shared definitions for the stream-control stages (splitter,
//                merger). Holds the common FSM state encoding so that one
//                controller can decode the state of every stage the same way,
//                plus the default widths used by those stages.
//  Revision    : 1.0 - initial release
// ============================================================================
package axis_ctrl_pkg;

    // State encoding shared with the packet splitter.
    localparam int c_FSM_WIDTH = 2;

    localparam logic [c_FSM_WIDTH-1:0] c_STR = 2'd0;  // idle
    localparam logic [c_FSM_WIDTH-1:0] c_OPE = 2'd1;  // operating
    localparam logic [c_FSM_WIDTH-1:0] c_ERR = 2'd2;  // error
    localparam logic [c_FSM_WIDTH-1:0] c_END = 2'd3;  // done

    // Default widths.
    localparam int c_DEF_DATA_WIDTH = 16;
    localparam int c_DEF_SIDE_WIDTH = 8;
    localparam int c_DEF_PCKT_WIDTH = 32;
    localparam int c_DEF_CNT_WIDTH  = 16;

endpackage
`default_nettype wire

// File: rtl/axis_register.sv
`default_nettype none
// ============================================================================
//  Module      : axis_register
//  Description : AXI-Stream register slice.
//                REG_TYPE = 0 : bypass (wires only)
//                REG_TYPE = 1 : simple pipeline register (ready is combinational)
//                REG_TYPE = 2 : skid buffer (all outputs registered, full rate)
//  Ports       : clk, rst                 - clock, synchronous active-high reset
//                s_axis_*                 - input stream
//                m_axis_*                 - output stream
//  Revision    : 1.0 - initial release
// ============================================================================
module axis_register #(
    parameter int DATA_WIDTH  = 16,
    parameter int KEEP_WIDTH  = 2,
    parameter int LAST_ENABLE = 1,
    parameter int ID_WIDTH    = 1,
    parameter int DEST_WIDTH  = 1,
    parameter int USER_WIDTH  = 1,
    parameter int REG_TYPE    = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] s_axis_tdata,
    input  logic [KEEP_WIDTH-1:0] s_axis_tkeep,
    input  logic                  s_axis_tvalid,
    output logic                  s_axis_tready,
    input  logic                  s_axis_tlast,
    input  logic [ID_WIDTH-1:0]   s_axis_tid,
    input  logic [DEST_WIDTH-1:0] s_axis_tdest,
    input  logic [USER_WIDTH-1:0] s_axis_tuser,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic [KEEP_WIDTH-1:0] m_axis_tkeep,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic                  m_axis_tlast,
    output logic [ID_WIDTH-1:0]   m_axis_tid,
    output logic [DEST_WIDTH-1:0] m_axis_tdest,
    output logic [USER_WIDTH-1:0] m_axis_tuser
);

    // All payload fields travel as one packed word.
    localparam int c_W = DATA_WIDTH + KEEP_WIDTH + 1 + ID_WIDTH + DEST_WIDTH + USER_WIDTH;

    logic [c_W-1:0] w_in;
    logic [c_W-1:0] w_out;
    logic           w_out_valid;
    logic           w_s_ready;

    assign w_in = {s_axis_tdata, s_axis_tkeep, (LAST_ENABLE != 0) ? s_axis_tlast : 1'b0,
                   s_axis_tid, s_axis_tdest, s_axis_tuser};

    assign {m_axis_tdata, m_axis_tkeep, m_axis_tlast, m_axis_tid, m_axis_tdest, m_axis_tuser} = w_out;
    assign m_axis_tvalid = w_out_valid;
    assign s_axis_tready = w_s_ready;

    generate
        if (REG_TYPE > 1) begin : g_skid
            logic [c_W-1:0] r_m_data;
            logic [c_W-1:0] r_t_data;
            logic           r_m_valid;
            logic           r_t_valid;
            logic           r_s_ready;
            logic           w_s_ready_early;

            // Ready for the next cycle: the sink drains us, or the temp slot is
            // free and the output slot will not be filled this cycle.
            assign w_s_ready_early = m_axis_tready | (~r_t_valid & (~r_m_valid | ~s_axis_tvalid));

            always_ff @(posedge clk) begin
                if (rst) begin
                    r_m_valid <= 1'b0;
                    r_t_valid <= 1'b0;
                    r_s_ready <= 1'b0;
                    r_m_data  <= '0;
                    r_t_data  <= '0;
                end else begin
                    r_s_ready <= w_s_ready_early;
                    if (r_s_ready) begin
                        if (m_axis_tready | ~r_m_valid) begin
                            r_m_valid <= s_axis_tvalid;
                            r_m_data  <= w_in;
                        end else begin
                            // Output stalled: park the incoming beat in the skid slot.
                            r_t_valid <= s_axis_tvalid;
                            r_t_data  <= w_in;
                        end
                    end else if (m_axis_tready) begin
                        r_m_valid <= r_t_valid;
                        r_m_data  <= r_t_data;
                        r_t_valid <= 1'b0;
                    end
                end
            end

            assign w_out       = r_m_data;
            assign w_out_valid = r_m_valid;
            assign w_s_ready   = r_s_ready;
        end else if (REG_TYPE == 1) begin : g_simple
            logic [c_W-1:0] r_m_data;
            logic           r_m_valid;

            assign w_s_ready = m_axis_tready | ~r_m_valid;

            always_ff @(posedge clk) begin
                if (rst) begin
                    r_m_valid <= 1'b0;
                    r_m_data  <= '0;
                end else if (w_s_ready) begin
                    r_m_valid <= s_axis_tvalid;
                    r_m_data  <= w_in;
                end
            end

            assign w_out       = r_m_data;
            assign w_out_valid = r_m_valid;
        end else begin : g_bypass
            assign w_out       = w_in;
            assign w_out_valid = s_axis_tvalid;
            assign w_s_ready   = m_axis_tready;
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/axis_packet_merger.sv
`default_nettype none
// ============================================================================
//  Module      : axis_packet_merger
//  Description : Merges every pckt_num consecutive fixed-size input packets
//                (pckt_size beats each) into one output packet. Internal tlast
//                is stripped; tlast is regenerated on the last merged beat.
//                Input tlast is optionally checked against the expected packet
//                boundary (CHECK_SIZE). Output goes through a skid buffer.
//  Ports       : clk, rst            - clock, synchronous active-high reset
//                operation_start     - start request (latches pckt_size/num)
//                pckt_size/pckt_num  - beats per packet / packets per merge
//                lock                - freeze request
//                external_error      - force ERR from any state
//                operation_busy      - in OPE state
//                operation_complete  - one-cycle done pulse
//                operation_error     - one-cycle error pulse
//                transmission        - registered m_axis handshake
//                s_axis_* / m_axis_* - input / output AXI-Stream
//  Config      : `AXIS_PACKET_MERGER_LOCK_EN - when defined, lock=1 freezes the
//                FSM and counters and holds s_axis_tready low; when undefined
//                the lock port is ignored.
//  Revision    : 1.0 - initial release
// ============================================================================
module axis_packet_merger
    import axis_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH  = c_DEF_DATA_WIDTH,
    parameter int KEEP_ENABLE = (DATA_WIDTH > 8),
    parameter int KEEP_WIDTH  = KEEP_ENABLE ? (DATA_WIDTH + 7) / 8 : 1,
    parameter int ID_ENABLE   = 0,
    parameter int DEST_ENABLE = 0,
    parameter int USER_ENABLE = 0,
    parameter int ID_WIDTH    = ID_ENABLE   ? c_DEF_SIDE_WIDTH : 1,
    parameter int DEST_WIDTH  = DEST_ENABLE ? c_DEF_SIDE_WIDTH : 1,
    parameter int USER_WIDTH  = USER_ENABLE ? c_DEF_SIDE_WIDTH : 1,
    parameter int PCKT_WIDTH  = c_DEF_PCKT_WIDTH,
    parameter int CNT_WIDTH   = c_DEF_CNT_WIDTH,
    parameter int CHECK_SIZE  = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  operation_start,
    input  logic [PCKT_WIDTH-1:0] pckt_size,
    input  logic [CNT_WIDTH-1:0]  pckt_num,
    input  logic                  lock,
    input  logic                  external_error,
    output logic                  operation_busy,
    output logic                  operation_complete,
    output logic                  operation_error,
    output logic                  transmission,
    input  logic [DATA_WIDTH-1:0] s_axis_tdata,
    input  logic [KEEP_WIDTH-1:0] s_axis_tkeep,
    input  logic                  s_axis_tvalid,
    output logic                  s_axis_tready,
    input  logic                  s_axis_tlast,
    input  logic [ID_WIDTH-1:0]   s_axis_tid,
    input  logic [DEST_WIDTH-1:0] s_axis_tdest,
    input  logic [USER_WIDTH-1:0] s_axis_tuser,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic [KEEP_WIDTH-1:0] m_axis_tkeep,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic                  m_axis_tlast,
    output logic [ID_WIDTH-1:0]   m_axis_tid,
    output logic [DEST_WIDTH-1:0] m_axis_tdest,
    output logic [USER_WIDTH-1:0] m_axis_tuser
);

    localparam logic [PCKT_WIDTH-1:0] c_ONE_P = {{(PCKT_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [CNT_WIDTH-1:0]  c_ONE_C = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    logic [c_FSM_WIDTH-1:0] r_state;
    logic [PCKT_WIDTH-1:0]  r_size_m1;
    logic [CNT_WIDTH-1:0]   r_num_m1;
    logic [PCKT_WIDTH-1:0]  r_beat_cnt;
    logic [CNT_WIDTH-1:0]   r_pkt_cnt;
    logic                   r_busy;
    logic                   r_complete;
    logic                   r_error;
    logic                   r_transmission;

    // ------------------------------------------------------------------------
    // Combinational
    // ------------------------------------------------------------------------
    logic [c_FSM_WIDTH-1:0] w_state_nxt;
    logic [PCKT_WIDTH-1:0]  w_size_nxt;
    logic [CNT_WIDTH-1:0]   w_num_nxt;
    logic [PCKT_WIDTH-1:0]  w_beat_nxt;
    logic [CNT_WIDTH-1:0]   w_pkt_nxt;
    logic                   w_lock;
    logic                   w_skid_ready;
    logic                   w_s_ready;
    logic                   w_accept;
    logic                   w_exp_last;
    logic                   w_pkt_last;
    logic                   w_size_err;
    logic                   w_fwd_last;
    logic                   w_start_bad;
    logic [KEEP_WIDTH-1:0]  w_keep_in;
    logic [ID_WIDTH-1:0]    w_id_in;
    logic [DEST_WIDTH-1:0]  w_dest_in;
    logic [USER_WIDTH-1:0]  w_user_in;

`ifdef AXIS_PACKET_MERGER_LOCK_EN
    assign w_lock = lock;
`else
    assign w_lock = 1'b0;
    logic  w_unused_lock;
    assign w_unused_lock = lock;
`endif

    // Disabled sidebands are driven with constants so the skid buffer sees
    // a fixed value and the dead bits fold away.
    assign w_keep_in = (KEEP_ENABLE != 0) ? s_axis_tkeep : {KEEP_WIDTH{1'b1}};
    assign w_id_in   = (ID_ENABLE   != 0) ? s_axis_tid   : '0;
    assign w_dest_in = (DEST_ENABLE != 0) ? s_axis_tdest : '0;
    assign w_user_in = (USER_ENABLE != 0) ? s_axis_tuser : '0;

    assign w_s_ready   = r_busy & w_skid_ready & ~w_lock;
    assign w_accept    = s_axis_tvalid & w_s_ready;
    assign w_exp_last  = (r_beat_cnt == r_size_m1);
    assign w_pkt_last  = (r_pkt_cnt == r_num_m1);
    assign w_size_err  = (CHECK_SIZE != 0) && (s_axis_tlast != w_exp_last);
    assign w_start_bad = (pckt_size == '0) || (pckt_num == '0);

    // Any beat that ends the operation (merge done, size error, forced error)
    // closes the downstream packet so the sink never sees a dangling frame.
    assign w_fwd_last  = w_size_err | (w_exp_last & w_pkt_last) | external_error;

    // Next-state / counter logic.
    always_comb begin
        w_state_nxt = r_state;
        w_size_nxt  = r_size_m1;
        w_num_nxt   = r_num_m1;
        w_beat_nxt  = r_beat_cnt;
        w_pkt_nxt   = r_pkt_cnt;

        if (external_error) begin
            w_state_nxt = c_ERR;
        end else if (!w_lock) begin
            case (r_state)
                c_STR, c_END: begin
                    w_state_nxt = c_STR;
                    if (operation_start) begin
                        if (w_start_bad) begin
                            w_state_nxt = c_ERR;
                        end else begin
                            w_state_nxt = c_OPE;
                            w_size_nxt  = pckt_size - c_ONE_P;
                            w_num_nxt   = pckt_num - c_ONE_C;
                            w_beat_nxt  = '0;
                            w_pkt_nxt   = '0;
                        end
                    end
                end
                c_OPE: begin
                    if (w_accept) begin
                        if (w_size_err) begin
                            w_state_nxt = c_ERR;
                        end else if (w_exp_last && w_pkt_last) begin
                            w_state_nxt = c_END;
                        end else if (w_exp_last) begin
                            w_beat_nxt = '0;
                            w_pkt_nxt  = r_pkt_cnt + c_ONE_C;
                        end else begin
                            w_beat_nxt = r_beat_cnt + c_ONE_P;
                        end
                    end
                end
                c_ERR: begin
                    w_state_nxt = c_STR;
                end
                default: begin
                    w_state_nxt = c_STR;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= c_STR;
            r_size_m1      <= '0;
            r_num_m1       <= '0;
            r_beat_cnt     <= '0;
            r_pkt_cnt      <= '0;
            r_busy         <= 1'b0;
            r_complete     <= 1'b0;
            r_error        <= 1'b0;
            r_transmission <= 1'b0;
        end else begin
            r_state        <= w_state_nxt;
            r_size_m1      <= w_size_nxt;
            r_num_m1       <= w_num_nxt;
            r_beat_cnt     <= w_beat_nxt;
            r_pkt_cnt      <= w_pkt_nxt;
            r_busy         <= (w_state_nxt == c_OPE);
            r_complete     <= (w_state_nxt == c_END);
            r_error        <= (w_state_nxt == c_ERR);
            r_transmission <= m_axis_tvalid & m_axis_tready;
        end
    end

    assign operation_busy     = r_busy;
    assign operation_complete = r_complete;
    assign operation_error    = r_error;
    assign transmission       = r_transmission;
    assign s_axis_tready      = w_s_ready;

    // ------------------------------------------------------------------------
    // Output stage: skid buffer, one cycle of latency, full throughput.
    // ------------------------------------------------------------------------
    axis_register #(
        .DATA_WIDTH  (DATA_WIDTH),
        .KEEP_WIDTH  (KEEP_WIDTH),
        .LAST_ENABLE (1),
        .ID_WIDTH    (ID_WIDTH),
        .DEST_WIDTH  (DEST_WIDTH),
        .USER_WIDTH  (USER_WIDTH),
        .REG_TYPE    (2)
    ) u_out_reg (
        .clk           (clk),
        .rst           (rst),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tkeep  (w_keep_in),
        .s_axis_tvalid (w_accept),
        .s_axis_tready (w_skid_ready),
        .s_axis_tlast  (w_fwd_last),
        .s_axis_tid    (w_id_in),
        .s_axis_tdest  (w_dest_in),
        .s_axis_tuser  (w_user_in),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tkeep  (m_axis_tkeep),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .m_axis_tlast  (m_axis_tlast),
        .m_axis_tid    (m_axis_tid),
        .m_axis_tdest  (m_axis_tdest),
        .m_axis_tuser  (m_axis_tuser)
    );

endmodule
`default_nettype wire

// File: tb/tb_axis_packet_merger.sv
`default_nettype none
// ============================================================================
//  Module      : tb_axis_packet_merger
//  Description : Directed self-checking bench for axis_packet_merger.
//                Lock scenario is exercised when AXIS_PACKET_MERGER_LOCK_EN
//                is defined.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_axis_packet_merger;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        operation_start = 1'b0;
    logic [31:0] pckt_size = '0;
    logic [15:0] pckt_num = '0;
    logic        lock = 1'b0;
    logic        external_error = 1'b0;
    logic        operation_busy;
    logic        operation_complete;
    logic        operation_error;
    logic        transmission;
    logic [15:0] s_axis_tdata = '0;
    logic [1:0]  s_axis_tkeep = '0;
    logic        s_axis_tvalid = 1'b0;
    logic        s_axis_tready;
    logic        s_axis_tlast = 1'b0;
    logic [0:0]  s_axis_tid = '0;
    logic [0:0]  s_axis_tdest = '0;
    logic [0:0]  s_axis_tuser = '0;
    logic [15:0] m_axis_tdata;
    logic [1:0]  m_axis_tkeep;
    logic        m_axis_tvalid;
    logic        m_axis_tready = 1'b1;
    logic        m_axis_tlast;
    logic [0:0]  m_axis_tid;
    logic [0:0]  m_axis_tdest;
    logic [0:0]  m_axis_tuser;

    axis_packet_merger u_dut (
        .clk                (clk),
        .rst                (rst),
        .operation_start    (operation_start),
        .pckt_size          (pckt_size),
        .pckt_num           (pckt_num),
        .lock               (lock),
        .external_error     (external_error),
        .operation_busy     (operation_busy),
        .operation_complete (operation_complete),
        .operation_error    (operation_error),
        .transmission       (transmission),
        .s_axis_tdata       (s_axis_tdata),
        .s_axis_tkeep       (s_axis_tkeep),
        .s_axis_tvalid      (s_axis_tvalid),
        .s_axis_tready      (s_axis_tready),
        .s_axis_tlast       (s_axis_tlast),
        .s_axis_tid         (s_axis_tid),
        .s_axis_tdest       (s_axis_tdest),
        .s_axis_tuser       (s_axis_tuser),
        .m_axis_tdata       (m_axis_tdata),
        .m_axis_tkeep       (m_axis_tkeep),
        .m_axis_tvalid      (m_axis_tvalid),
        .m_axis_tready      (m_axis_tready),
        .m_axis_tlast       (m_axis_tlast),
        .m_axis_tid         (m_axis_tid),
        .m_axis_tdest       (m_axis_tdest),
        .m_axis_tuser       (m_axis_tuser)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check_value(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    endtask

    // Output monitor: {keep, last, data} of every accepted output beat.
    logic [18:0] out_q[$];
    int   n_cpl, n_err, n_last_cpl, n_tx_bad;
    logic busy_seen;
    logic prev_hs = 1'b0;
    logic tog_en = 1'b0;

    always @(negedge clk) begin
        if (m_axis_tvalid && m_axis_tready) begin
            out_q.push_back({m_axis_tkeep, m_axis_tlast, m_axis_tdata});
            if (m_axis_tlast && operation_complete) n_last_cpl++;
        end
        if (operation_complete) n_cpl++;
        if (operation_error)    n_err++;
        if (operation_busy)     busy_seen = 1'b1;
        if (rst) begin
            prev_hs = 1'b0;
        end else begin
            if (transmission !== prev_hs) n_tx_bad++;
            prev_hs = m_axis_tvalid && m_axis_tready;
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (tog_en) m_axis_tready = ~m_axis_tready;
        end
    end

    task automatic clear_mon();
        out_q.delete();
        n_cpl = 0; n_err = 0; n_last_cpl = 0;
        busy_seen = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_op(input logic [31:0] sz, input logic [15:0] num);
        pckt_size = sz;
        pckt_num = num;
        operation_start = 1'b1;
        tick();
        operation_start = 1'b0;
    endtask

    task automatic drive_beat(input logic [15:0] d, input logic [1:0] k, input logic l,
                              input int budget, output logic ok);
        s_axis_tdata = d; s_axis_tkeep = k; s_axis_tlast = l; s_axis_tvalid = 1'b1;
        ok = 1'b0;
        for (int c = 0; c < budget && !ok; c++) begin
            @(negedge clk);
            if (s_axis_tready) ok = 1'b1;
            tick();
        end
        s_axis_tvalid = 1'b0;
    endtask

    task automatic wait_out(input int n);
        for (int c = 0; c < 60 && out_q.size() < n; c++) tick();
        repeat (3) tick();
    endtask

    function automatic logic [18:0] out_at(input int i);
        if (i < out_q.size()) return out_q[i];
        return '1;
    endfunction

    logic ok;

    initial begin
        clear_mon();
        n_tx_bad = 0;
        repeat (4) tick();
        rst = 1'b0;
        tick();

        // Reset state
        check_value("rst_busy",  operation_busy, 0);
        check_value("rst_flags", {operation_complete, operation_error, transmission}, 0);
        check_value("rst_mvalid", m_axis_tvalid, 0);
        check_value("rst_sready", s_axis_tready, 0);

        // 1: size 4 x 3, normal merge
        clear_mon();
        start_op(4, 3);
        check_value("t1_busy_lat", operation_busy, 1);
        check_value("t1_sready_lat", s_axis_tready, 1);
        for (int i = 0; i < 12; i++) begin
            drive_beat(16'h0100 + 16'(i), (i % 2 == 1) ? 2'b01 : 2'b11, (i % 4 == 3), 20, ok);
            check_value($sformatf("t1_acc%0d", i), ok, 1);
        end
        wait_out(12);
        check_value("t1_count", out_q.size(), 12);
        for (int i = 0; i < 12; i++)
            check_value($sformatf("t1_beat%0d", i), out_at(i),
                        {(i % 2 == 1) ? 2'b01 : 2'b11, (i == 11), 16'h0100 + 16'(i)});
        check_value("t1_cpl", n_cpl, 1);
        check_value("t1_err", n_err, 0);
        check_value("t1_last_with_cpl", n_last_cpl, 1);
        check_value("t1_idle", operation_busy, 0);

        // 2: early tlast on beat 3
        clear_mon();
        start_op(4, 3);
        for (int i = 0; i < 3; i++) begin
            drive_beat(16'h0200 + 16'(i), 2'b11, (i == 2), 20, ok);
            check_value($sformatf("t2_acc%0d", i), ok, 1);
        end
        drive_beat(16'h0203, 2'b11, 1'b0, 6, ok);
        check_value("t2_rejected", ok, 0);
        wait_out(3);
        check_value("t2_count", out_q.size(), 3);
        for (int i = 0; i < 3; i++)
            check_value($sformatf("t2_beat%0d", i), out_at(i), {2'b11, (i == 2), 16'h0200 + 16'(i)});
        check_value("t2_err", n_err, 1);
        check_value("t2_cpl", n_cpl, 0);
        check_value("t2_busy", operation_busy, 0);

        // 3: size 2 x 2 with 50% backpressure
        clear_mon();
        tog_en = 1'b1;
        start_op(2, 2);
        for (int i = 0; i < 4; i++) begin
            drive_beat(16'h0A00 + 16'(i), 2'b11, (i % 2 == 1), 20, ok);
            check_value($sformatf("t3_acc%0d", i), ok, 1);
        end
        wait_out(4);
        tog_en = 1'b0;
        m_axis_tready = 1'b1;
        tick();
        check_value("t3_count", out_q.size(), 4);
        for (int i = 0; i < 4; i++)
            check_value($sformatf("t3_beat%0d", i), out_at(i), {2'b11, (i == 3), 16'h0A00 + 16'(i)});
        check_value("t3_cpl", n_cpl, 1);

        // 4: pckt_num = 0
        clear_mon();
        start_op(4, 0);
        repeat (4) tick();
        check_value("t4_err", n_err, 1);
        check_value("t4_busy_seen", busy_seen, 0);
        check_value("t4_count", out_q.size(), 0);

`ifdef AXIS_PACKET_MERGER_LOCK_EN
        // 5: lock for 5 cycles mid-packet
        begin
            int n_lock_rdy;
            n_lock_rdy = 0;
            clear_mon();
            start_op(4, 1);
            for (int i = 0; i < 2; i++) begin
                drive_beat(16'h0500 + 16'(i), 2'b11, 1'b0, 20, ok);
                check_value($sformatf("t5_acc%0d", i), ok, 1);
            end
            lock = 1'b1;
            s_axis_tdata = 16'h0502; s_axis_tlast = 1'b0; s_axis_tvalid = 1'b1;
            repeat (5) begin
                @(negedge clk);
                if (s_axis_tready) n_lock_rdy++;
                tick();
            end
            check_value("t5_lock_rdy", n_lock_rdy, 0);
            check_value("t5_lock_busy", operation_busy, 1);
            lock = 1'b0;
            for (int i = 2; i < 4; i++) begin
                drive_beat(16'h0500 + 16'(i), 2'b11, (i == 3), 20, ok);
                check_value($sformatf("t5_acc%0d", i), ok, 1);
            end
            wait_out(4);
            check_value("t5_count", out_q.size(), 4);
            for (int i = 0; i < 4; i++)
                check_value($sformatf("t5_beat%0d", i), out_at(i), {2'b11, (i == 3), 16'h0500 + 16'(i)});
            check_value("t5_cpl", n_cpl, 1);
        end
`endif

        // 6: reset after 3 of 8 beats, then a fresh operation
        clear_mon();
        start_op(8, 1);
        for (int i = 0; i < 3; i++) begin
            drive_beat(16'h0600 + 16'(i), 2'b11, 1'b0, 20, ok);
            check_value($sformatf("t6_acc%0d", i), ok, 1);
        end
        rst = 1'b1;
        tick();
        check_value("t6_rst_flags", {operation_busy, operation_complete, operation_error}, 0);
        check_value("t6_rst_mvalid", m_axis_tvalid, 0);
        check_value("t6_rst_sready", s_axis_tready, 0);
        rst = 1'b0;
        repeat (2) tick();
        clear_mon();
        start_op(8, 1);
        for (int i = 0; i < 8; i++) begin
            drive_beat(16'h0610 + 16'(i), 2'b01, (i == 7), 20, ok);
            check_value($sformatf("t6_acc_b%0d", i), ok, 1);
        end
        wait_out(8);
        check_value("t6_count", out_q.size(), 8);
        for (int i = 0; i < 8; i++)
            check_value($sformatf("t6_beat%0d", i), out_at(i), {2'b01, (i == 7), 16'h0610 + 16'(i)});
        check_value("t6_cpl", n_cpl, 1);
        check_value("t6_err", n_err, 0);

        // 7: external_error together with the final beat
        clear_mon();
        start_op(2, 1);
        drive_beat(16'h0700, 2'b11, 1'b0, 20, ok);
        check_value("t7_acc0", ok, 1);
        external_error = 1'b1;
        drive_beat(16'h0701, 2'b11, 1'b1, 20, ok);
        external_error = 1'b0;
        check_value("t7_acc1", ok, 1);
        wait_out(2);
        check_value("t7_count", out_q.size(), 2);
        check_value("t7_beat0", out_at(0), {2'b11, 1'b0, 16'h0700});
        check_value("t7_beat1", out_at(1), {2'b11, 1'b1, 16'h0701});
        check_value("t7_err", n_err, 1);
        check_value("t7_cpl", n_cpl, 0);

        check_value("transmission_track", n_tx_bad, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
